uart_buffered: RTL and testbench

Parametrised, self-contained successor to the table-driven UART top level. It adds:
- a runtime-programmable 16-bit baud divisor with 16x oversampling;
- odd/even parity selection;
- independent TX and RX FIFOs of parametrised depth, with per-word error flags and sticky overrun detection.

It sits between fabric-side ready/valid streams and the serial pins.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_buffered.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state codes and config bundle for the buffered UART.
// Included by the UART top and its FIFO.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 8;
  localparam int MIN_WORD     = 5;
  localparam int MAX_WORD     = 16;

  localparam logic [3:0] DEF_WORD     = 4'd8;
  localparam logic       DEF_PAR_EN   = 1'b1;
  localparam logic       DEF_PAR_ODD  = 1'b0;
  localparam logic       DEF_TWO_STOP = 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef struct packed {
    logic [15:0] div;
    logic [3:0]  word;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
  } cfg_t;

  function automatic logic parity_of(
    input logic [MAX_WORD-1:0] d,
    input logic [3:0]          ws,
    input logic                odd
  );
    logic p;
    p = odd;
    for (int i = 0; i < MAX_WORD; i++)
      if (i < int'(ws)) p = p ^ d[i];
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    used;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign used    = wr_ptr - rd_ptr;
  assign o_level = LW'(used);
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: programmable 16x baud tick, parity, TX/RX FIFOs.
// Config is shadowed and applied only while both engines are idle.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 650
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_cfg_valid,
  input  logic [15:0]                     i_baud_div,
  input  logic [3:0]                      i_word_size,
  input  logic                            i_parity_en,
  input  logic                            i_parity_odd,
  input  logic                            i_two_stop,
  output logic                            o_cfg_pending,
  input  logic [DATA_W-1:0]               i_tx_data,
  input  logic                            i_tx_valid,
  output logic                            o_tx_ready,
  output logic [DATA_W-1:0]               o_rx_data,
  output logic                            o_rx_perr,
  output logic                            o_rx_ferr,
  output logic                            o_rx_valid,
  input  logic                            i_rx_ready,
  output logic                            o_overrun,
  input  logic                            i_clear_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_tx_level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_rx_level,
  input  logic                            i_rx,
  output logic                            o_tx
);

  localparam cfg_t DEF_CFG = '{
    div:      16'(DEFAULT_DIV),
    word:     DEF_WORD,
    par_en:   DEF_PAR_EN,
    par_odd:  DEF_PAR_ODD,
    two_stop: DEF_TWO_STOP
  };

  cfg_t        act;
  cfg_t        shadow;
  logic        pending;
  logic        cfg_ok;
  logic        apply;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  ws_last;

  logic [2:0]        tx_st;
  logic [4:0]        tx_tcnt;
  logic [3:0]        tx_bit;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_par;
  logic [DATA_W-1:0] tx_rdata;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_pop;
  logic              tx_bit_end;
  logic              tx_stop_end;
  logic [4:0]        stop_last;

  logic [1:0]        rx_sync;
  logic              rx_s;
  logic              rx_prev;
  logic [2:0]        rx_st;
  logic [3:0]        rx_tcnt;
  logic [3:0]        rx_bit;
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr_q;
  logic              rx_sample;
  logic              rx_push;
  logic [DATA_W+1:0] rx_wdata;
  logic [DATA_W+1:0] rx_rdata;
  logic              rx_full;
  logic              rx_empty;
  logic              ovr;

  assign cfg_ok = (i_word_size >= 4'(MIN_WORD)) &&
                  (i_word_size <= 4'(DATA_W));
  assign apply  = pending && (tx_st == ST_IDLE) &&
                  (rx_st == ST_IDLE);
  assign o_cfg_pending = pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act     <= DEF_CFG;
      shadow  <= DEF_CFG;
      pending <= 1'b0;
    end else begin
      if (apply) act <= shadow;
      if (i_cfg_valid && cfg_ok) begin
        shadow  <= '{i_baud_div, i_word_size, i_parity_en,
                     i_parity_odd, i_two_stop};
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  assign tick = (tick_cnt == act.div);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      tick_cnt <= '0;
    else if (apply || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 16'd1;
  end

  assign ws_last = act.word - 4'd1;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_tx_valid),
    .i_wdata (i_tx_data),
    .i_pop   (tx_pop),
    .o_rdata (tx_rdata),
    .o_full  (tx_full),
    .o_empty (tx_empty),
    .o_level (o_tx_level)
  );

  assign o_tx_ready  = !tx_full;
  assign tx_pop      = (tx_st == ST_IDLE) && tick && !tx_empty;
  assign tx_bit_end  = tick && (tx_tcnt == 5'(OVERSAMPLE - 1));
  // STOP ends one tick early: the IDLE tick completes the stop bit.
  assign stop_last   = act.two_stop ? 5'(2 * OVERSAMPLE - 2)
                                    : 5'(OVERSAMPLE - 2);
  assign tx_stop_end = tick && (tx_tcnt == stop_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_st   <= ST_IDLE;
      tx_tcnt <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
    end else begin
      if (tx_st != ST_IDLE && tick) tx_tcnt <= tx_tcnt + 5'd1;
      unique case (tx_st)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_st   <= ST_START;
            tx_tcnt <= '0;
            tx_sh   <= tx_rdata;
            tx_par  <= parity_of(MAX_WORD'(tx_rdata),
                                 act.word, act.par_odd);
          end
        end
        ST_START: begin
          if (tx_bit_end) begin
            tx_st   <= ST_DATA;
            tx_tcnt <= '0;
            tx_bit  <= '0;
          end
        end
        ST_DATA: begin
          if (tx_bit_end) begin
            tx_tcnt <= '0;
            tx_sh   <= tx_sh >> 1;
            tx_bit  <= tx_bit + 4'd1;
            if (tx_bit == ws_last)
              tx_st <= act.par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (tx_bit_end) begin
            tx_st   <= ST_STOP;
            tx_tcnt <= '0;
          end
        end
        ST_STOP: begin
          if (tx_stop_end) begin
            tx_st   <= ST_IDLE;
            tx_tcnt <= '0;
          end
        end
        default: tx_st <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_tx = 1'b1;
    unique case (tx_st)
      ST_START:  o_tx = 1'b0;
      ST_DATA:   o_tx = tx_sh[0];
      ST_PARITY: o_tx = tx_par;
      default:   o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], i_rx};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_s      = rx_sync[1];
  assign rx_sample = tick && (rx_tcnt == 4'(SAMPLE_POINT - 1));
  assign rx_push   = (rx_st == ST_STOP) && rx_sample;
  assign rx_wdata  = {~rx_s, rx_perr_q, rx_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_st     <= ST_IDLE;
      rx_tcnt   <= '0;
      rx_bit    <= '0;
      rx_data   <= '0;
      rx_perr_q <= 1'b0;
    end else begin
      if (rx_st != ST_IDLE && tick) rx_tcnt <= rx_tcnt + 4'd1;
      unique case (rx_st)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_st     <= ST_START;
            rx_tcnt   <= '0;
            rx_bit    <= '0;
            rx_data   <= '0;
            rx_perr_q <= 1'b0;
          end
        end
        ST_START: begin
          if (rx_sample) rx_st <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (rx_sample) begin
            rx_data[rx_bit] <= rx_s;
            rx_bit          <= rx_bit + 4'd1;
            if (rx_bit == ws_last)
              rx_st <= act.par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (rx_sample) begin
            rx_perr_q <= parity_of(MAX_WORD'(rx_data), act.word,
                                   act.par_odd) != rx_s;
            rx_st     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (rx_sample) rx_st <= ST_IDLE;
        end
        default: rx_st <= ST_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rx_push),
    .i_wdata (rx_wdata),
    .i_pop   (i_rx_ready),
    .o_rdata (rx_rdata),
    .o_full  (rx_full),
    .o_empty (rx_empty),
    .o_level (o_rx_level)
  );

  assign o_rx_data  = rx_rdata[DATA_W-1:0];
  assign o_rx_perr  = rx_rdata[DATA_W];
  assign o_rx_ferr  = rx_rdata[DATA_W+1];
  assign o_rx_valid = !rx_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ovr <= 1'b0;
    else if (rx_push && rx_full)
      ovr <= 1'b1;
    else if (i_clear_err)
      ovr <= 1'b0;
  end

  assign o_overrun = ovr;

endmodule

// File: tb/tb_uart_buffered.sv
// Directed + randomized bench for uart_buffered, depth-4 FIFOs.
// Line waveforms and RX words are predicted from frame arithmetic.
module tb_uart_buffered;

  localparam int DW    = 9;
  localparam int DEPTH = 4;
  localparam int DDIV  = 650;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic [15:0]   baud_div;
  logic [3:0]    word_size;
  logic          parity_en;
  logic          parity_odd;
  logic          two_stop;
  logic          cfg_pending;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_perr;
  logic          rx_ferr;
  logic          rx_valid;
  logic          rx_ready;
  logic          overrun;
  logic          clear_err;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          rx_in;
  logic          tx;
  logic          loop;
  logic          rx_drv;

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];
  int   rxq[$];

  always #5 clk = ~clk;
  assign rx_in = loop ? tx : rx_drv;

  uart_buffered #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cfg_valid   (cfg_valid),
    .i_baud_div    (baud_div),
    .i_word_size   (word_size),
    .i_parity_en   (parity_en),
    .i_parity_odd  (parity_odd),
    .i_two_stop    (two_stop),
    .o_cfg_pending (cfg_pending),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_perr     (rx_perr),
    .o_rx_ferr     (rx_ferr),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .o_overrun     (overrun),
    .i_clear_err   (clear_err),
    .o_tx_level    (tx_level),
    .o_rx_level    (rx_level),
    .i_rx          (rx_in),
    .o_tx          (tx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_par(input int w, input int ws,
                                   input logic odd);
    return logic'($countones(w & ((1 << ws) - 1)) % 2) ^ odd;
  endfunction

  function automatic void add_frame(input int w, input int ws,
                                    input logic pen, input logic podd,
                                    input logic two);
    exp_q.push_back(1'b0);
    for (int i = 0; i < ws; i++) exp_q.push_back(logic'((w >> i) & 1));
    if (pen) exp_q.push_back(ref_par(w, ws, podd));
    exp_q.push_back(1'b1);
    if (two) exp_q.push_back(1'b1);
  endfunction

  task automatic cfg(input int div, input int ws, input logic pen,
                     input logic podd, input logic two);
    int n;
    baud_div   = 16'(div);
    word_size  = 4'(ws);
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = two;
    cfg_valid  = 1'b1;
    step();
    cfg_valid = 1'b0;
    n = 0;
    while (cfg_pending && n < 20000) begin
      step();
      n++;
    end
    check("cfg_applied", 32'(cfg_pending), 0);
  endtask

  task automatic push(input int w);
    tx_data  = DW'(w);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output int n);
    n = 0;
    while (tx !== 1'b0 && n < maxc) begin
      step();
      n++;
    end
    check("start_seen", 32'(tx), 0);
  endtask

  // Called at the start of the first expected bit, `skip` cycles late.
  task automatic check_line(input string tag, input int p,
                            input int skip);
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_n(i == 0 ? p / 2 - skip : p);
      check($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic rx_send(input int w, input int ws, input logic pen,
                         input logic podd, input logic flip,
                         input logic stopb, input int p);
    rx_drv = 1'b0;
    wait_n(p);
    for (int i = 0; i < ws; i++) begin
      rx_drv = logic'((w >> i) & 1);
      wait_n(p);
    end
    if (pen) begin
      rx_drv = ref_par(w, ws, podd) ^ flip;
      wait_n(p);
    end
    rx_drv = stopb;
    wait_n(p);
    rx_drv = 1'b1;
    wait_n(p);
  endtask

  task automatic loop_run(input string tag, input int div,
                          input int ws, input logic pen,
                          input logic podd, input logic two,
                          input int w0, input int w1, input int w2);
    int n;
    int m;
    m = (1 << ws) - 1;
    cfg(div, ws, pen, podd, two);
    push(w0);
    wait_start(div + 4, n);
    check({tag, " latency"}, 32'(n <= div + 3), 1);
    push(w1);
    push(w2);
    add_frame(w0, ws, pen, podd, two);
    add_frame(w1, ws, pen, podd, two);
    add_frame(w2, ws, pen, podd, two);
    check_line(tag, 16 * (div + 1), 2);
    wait_n(16 * (div + 1));
    check({tag, " rx_level"}, 32'(rx_level), 3);
    rxq = '{w0 & m, w1 & m, w2 & m};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s rx_data%0d", tag, i), 32'(rx_data), rxq[i]);
      check($sformatf("%s rx_perr%0d", tag, i), 32'(rx_perr), 0);
      check($sformatf("%s rx_ferr%0d", tag, i), 32'(rx_ferr), 0);
      pop();
    end
  endtask

  initial begin
    int n;
    int w;
    int c;
    int ws;
    logic pen;
    logic podd;
    logic two;

    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    baud_div   = '0;
    word_size  = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    clear_err  = 1'b0;
    loop       = 1'b0;
    rx_drv     = 1'b1;
    wait_n(3);
    rst_n = 1'b1;
    step();

    check("rst tx", 32'(tx), 1);
    check("rst tx_level", 32'(tx_level), 0);
    check("rst rx_level", 32'(rx_level), 0);
    check("rst tx_ready", 32'(tx_ready), 1);
    check("rst rx_valid", 32'(rx_valid), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst cfg_pending", 32'(cfg_pending), 0);

    push(int'($urandom_range(0, 255)));
    push(int'($urandom_range(0, 255)));
    wait_start(DDIV + 4, n);
    check("default latency", 32'(n <= DDIV + 3), 1);
    check("midframe tx_level", 32'(tx_level), 1);
    wait_n(100);
    rst_n = 1'b0;
    #1;
    check("midrst tx", 32'(tx), 1);
    check("midrst tx_level", 32'(tx_level), 0);
    check("midrst tx_ready", 32'(tx_ready), 1);
    check("midrst rx_valid", 32'(rx_valid), 0);
    check("midrst overrun", 32'(overrun), 0);
    step();
    rst_n = 1'b1;
    step();

    cfg(0, 8, 1'b1, 1'b0, 1'b0);
    push(32'hA5);
    wait_start(4, n);
    check("a5 latency", 32'(n <= 3), 1);
    c = 0;
    while (tx === 1'b0 && c < 100) begin
      step();
      c++;
    end
    check("a5 start_len", 32'(c), 16);
    exp_q = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    check_line("a5", 16, 0);
    wait_n(16);

    for (int it = 0; it < 3; it++) begin
      ws   = int'($urandom_range(5, 9));
      pen  = logic'($urandom_range(0, 1));
      podd = logic'($urandom_range(0, 1));
      two  = logic'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 511));
      cfg(0, ws, pen, podd, two);
      push(w);
      wait_start(4, n);
      check($sformatf("rtx%0d latency", it), 32'(n <= 3), 1);
      add_frame(w, ws, pen, podd, two);
      check_line($sformatf("rtx%0d", it), 16, 0);
      wait_n(40);
    end

    loop = 1'b1;
    loop_run("lb7o2", 3, 7, 1'b1, 1'b1, 1'b1, 32'h00, 32'h7F, 32'h55);
    for (int it = 0; it < 3; it++) begin
      loop_run($sformatf("rlb%0d", it), int'($urandom_range(0, 2)),
               int'($urandom_range(5, 9)),
               logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 1)),
               int'($urandom_range(0, 511)),
               int'($urandom_range(0, 511)),
               int'($urandom_range(0, 511)));
    end
    wait_n(200);
    loop = 1'b0;

    cfg(0, 8, 1'b1, 1'b0, 1'b0);
    rxq.delete();
    for (int i = 0; i < 5; i++) begin
      w = int'($urandom_range(0, 255));
      rxq.push_back(w);
      rx_send(w, 8, 1'b1, 1'b0, 1'b0, 1'b1, 16);
    end
    check("ovr rx_level", 32'(rx_level), 4);
    check("ovr overrun", 32'(overrun), 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr data%0d", i), 32'(rx_data), rxq[i]);
      check($sformatf("ovr perr%0d", i), 32'(rx_perr), 0);
      pop();
    end
    check("ovr still_set", 32'(overrun), 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("ovr cleared", 32'(overrun), 0);
    check("ovr drained", 32'(rx_valid), 0);

    rx_send(32'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 16);
    rx_send(32'hC1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 16);
    check("err rx_level", 32'(rx_level), 2);
    check("perr data", 32'(rx_data), 32'h3C);
    check("perr perr", 32'(rx_perr), 1);
    check("perr ferr", 32'(rx_ferr), 0);
    pop();
    check("ferr data", 32'(rx_data), 32'hC1);
    check("ferr perr", 32'(rx_perr), 0);
    check("ferr ferr", 32'(rx_ferr), 1);
    pop();

    cfg(0, 8, 1'b1, 1'b0, 1'b0);
    w = int'($urandom_range(0, 255));
    push(w);
    wait_start(4, n);
    c = 0;
    wait_n(20);
    c += 20;
    baud_div  = 16'd1;
    word_size = 4'd8;
    cfg_valid = 1'b1;
    step();
    c++;
    cfg_valid = 1'b0;
    check("midcfg pending", 32'(cfg_pending), 1);
    baud_div  = 16'd5;
    word_size = 4'd4;
    cfg_valid = 1'b1;
    step();
    c++;
    cfg_valid = 1'b0;
    wait_n(160 - c);
    c = 160;
    check("midcfg pending_late", 32'(cfg_pending), 1);
    while (cfg_pending && c < 400) begin
      step();
      c++;
    end
    check("midcfg clear_time", 32'(c >= 170 && c <= 180), 1);
    w = int'($urandom_range(0, 255));
    push(w);
    wait_start(5, n);
    check("div1 latency", 32'(n <= 4), 1);
    add_frame(w, 8, 1'b1, 1'b0, 1'b0);
    check_line("div1", 32, 0);
    word_size = 4'd4;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("ws4 ignored", 32'(cfg_pending), 0);
    word_size = 4'd10;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("ws10 ignored", 32'(cfg_pending), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
